// File: rtl/dffram_burst_port_if.sv
// dffram_burst_port_if: command, write/read stream and RAM macro pins of the burst port
interface dffram_burst_port_if #(
    parameter int A_WIDTH   = 9,
    parameter int LEN_WIDTH = 10
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [A_WIDTH-1:0]   cmd_addr;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [31:0]          wr_data;
    logic [3:0]           wr_strb;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [31:0]          rd_data;
    logic                 rd_last;
    logic                 done;
    logic                 ram_EN0;
    logic [3:0]           ram_WE0;
    logic [A_WIDTH-1:0]   ram_A0;
    logic [31:0]          ram_Di0;
    logic [31:0]          ram_Do0;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, wr_strb, rd_ready, ram_Do0,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, ram_EN0, ram_WE0, ram_A0, ram_Di0
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, wr_strb, rd_ready, ram_Do0,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, ram_EN0, ram_WE0, ram_A0, ram_Di0
    );
endinterface

// File: rtl/dffram_burst_port.sv
// dffram_burst_port: turns read/write burst commands into one-word-per-cycle DFFRAM accesses
module dffram_burst_port #(
    parameter int A_WIDTH   = 9,
    parameter int LEN_WIDTH = 10
) (
    input logic                CLK,
    input logic                rst,
    dffram_burst_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t               state;
    logic [A_WIDTH-1:0]   addr;
    logic [LEN_WIDTH-1:0] rem;
    logic                 inflight;
    logic                 inflight_last;
    logic [32:0]          fifo [2];
    logic                 wp;
    logic                 rp;
    logic [1:0]           count;
    logic                 wr_hs;
    logic                 pop;
    logic                 issue;
    logic [2:0]           occ;

    // Handshakes, read-issue throttle and RAM pins; everything is forced quiet while rst is high
    always_comb begin
        bus.cmd_ready = !rst && state == IDLE;
        bus.wr_ready  = !rst && state == WRITE;
        wr_hs         = bus.wr_valid && bus.wr_ready;
        bus.rd_valid  = !rst && count != 2'd0;
        pop           = bus.rd_valid && bus.rd_ready;
        occ           = 3'(count) + 3'(inflight) - 3'(pop);
        issue         = !rst && state == READ && rem != '0 && occ < 3'd2;
        bus.rd_data   = bus.rd_valid ? fifo[rp][31:0] : 32'h0;
        bus.rd_last   = bus.rd_valid && fifo[rp][32];
        bus.done      = !rst && state == DONE;
        bus.ram_EN0   = wr_hs || issue;
        bus.ram_WE0   = wr_hs ? bus.wr_strb : 4'h0;
        bus.ram_A0    = (wr_hs || issue) ? addr : '0;
        bus.ram_Di0   = wr_hs ? bus.wr_data : 32'h0;
    end

    // Burst FSM, address/length counters and the 2-entry read FIFO fed one cycle after each issue
    always_ff @(posedge CLK) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            rem           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wp            <= 1'b0;
            rp            <= 1'b0;
            count         <= 2'd0;
        end else begin
            inflight <= issue;
            if (issue)
                inflight_last <= rem == LEN_WIDTH'(1);
            if (inflight) begin
                fifo[wp] <= {inflight_last, bus.ram_Do0};
                wp       <= !wp;
            end
            if (pop)
                rp <= !rp;
            count <= count + 2'(inflight) - 2'(pop);
            if (wr_hs || issue) begin
                addr <= addr + A_WIDTH'(1);
                rem  <= rem - LEN_WIDTH'(1);
            end
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    addr  <= bus.cmd_addr;
                    rem   <= bus.cmd_len;
                    state <= bus.cmd_len == '0 ? DONE : (bus.cmd_write ? WRITE : READ);
                end
                WRITE: if (wr_hs && rem == LEN_WIDTH'(1)) state <= DONE;
                READ:  if (pop && bus.rd_last) state <= DONE;
                DONE:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dffram_burst_port.sv
// tb_dffram_burst_port: table-driven bursts against a behavioural DFFRAM model plus reset/backpressure sequences
module tb_dffram_burst_port;
    typedef struct {
        logic        wr;
        logic [8:0]  addr;
        logic [9:0]  len;
        logic [31:0] base;
        logic [3:0]  strb;
        int          done_cyc;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [31:0] mem [512];
    vec_t vecs [10];

    dffram_burst_port_if #(.A_WIDTH(9), .LEN_WIDTH(10)) bus ();

    dffram_burst_port #(.A_WIDTH(9), .LEN_WIDTH(10)) dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: byte-writable, registered read, output zero when disabled
    always @(posedge clk) begin
        if (bus.ram_EN0) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_WE0[b]) mem[bus.ram_A0][8*b +: 8] <= bus.ram_Di0[8*b +: 8];
            bus.ram_Do0 <= mem[bus.ram_A0];
        end else begin
            bus.ram_Do0 <= 32'h0;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int en_n;
        int rd_n;
        int errs;
        int done_at;
        en_n = 0; rd_n = 0; errs = 0; done_at = -1;
        bus.cmd_valid = 1'b1; bus.cmd_write = v.wr; bus.cmd_addr = v.addr; bus.cmd_len = v.len;
        bus.wr_valid = v.wr; bus.wr_data = v.base; bus.wr_strb = v.strb; bus.rd_ready = 1'b1;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == 0) chk($sformatf("v%0d cmd_ready", id), 32'(bus.cmd_ready), 32'd1);
            if (bus.ram_EN0) begin
                if (bus.ram_A0 != 9'(int'(v.addr) + en_n) || bus.ram_WE0 != (v.wr ? v.strb : 4'h0) ||
                    (v.wr && bus.ram_Di0 != v.base + 32'(en_n))) errs++;
                en_n++;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (bus.rd_data != v.base + 32'(rd_n) || bus.rd_last != (rd_n == int'(v.len) - 1)) errs++;
                rd_n++;
            end
            if (bus.done) done_at = c;
            else begin
                @(posedge clk); #1;
                bus.cmd_valid = 1'b0;
                bus.wr_data = v.base + 32'(en_n);
            end
        end
        bus.cmd_valid = 1'b0; bus.wr_valid = 1'b0;
        chk($sformatf("v%0d done_cycle", id), done_at, v.done_cyc);
        chk($sformatf("v%0d ram_accesses", id), en_n, 32'(v.len));
        chk($sformatf("v%0d rd_words", id), rd_n, v.wr ? 32'd0 : 32'(v.len));
        chk($sformatf("v%0d addr_data_errors", id), errs, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("v%0d cmd_ready_after", id), 32'(bus.cmd_ready), 32'd1);
        chk($sformatf("v%0d done_pulse_width", id), 32'(bus.done), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int iss, pops, viol, rd_n, derr, done_at, outst, bad;
        logic [3:0] pat;
        vec_t rv;
        tests = 0; fails = 0;
        vecs[0] = '{1'b1, 9'h1FE, 10'd4, 32'h000000A0, 4'hF, 5};
        vecs[1] = '{1'b0, 9'h1FE, 10'd4, 32'h000000A0, 4'h0, 7};
        vecs[2] = '{1'b1, 9'h010, 10'd8, 32'h00000100, 4'hF, 9};
        vecs[3] = '{1'b0, 9'h010, 10'd8, 32'h00000100, 4'h0, 11};
        vecs[4] = '{1'b1, 9'h000, 10'd0, 32'h00000000, 4'hF, 1};
        vecs[5] = '{1'b0, 9'h000, 10'd0, 32'h00000000, 4'h0, 1};
        vecs[6] = '{1'b0, 9'h1FF, 10'd2, 32'h000000A1, 4'h0, 5};
        vecs[7] = '{1'b1, 9'h020, 10'd1, 32'hFFFFFFFF, 4'hF, 2};
        vecs[8] = '{1'b1, 9'h020, 10'd1, 32'h11223344, 4'h5, 2};
        vecs[9] = '{1'b0, 9'h020, 10'd1, 32'hFF22FF44, 4'h0, 4};

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_strb = '0; bus.rd_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst ram_EN0", 32'(bus.ram_EN0), 32'd0);
        chk("rst rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst rd_valid", 32'(bus.rd_valid), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Read 8 under a 1,0,0,1 rd_ready pattern while a stray command is held on the cmd port
        pat = 4'b1001;
        iss = 0; pops = 0; viol = 0; rd_n = 0; derr = 0; done_at = -1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 9'h010; bus.cmd_len = 10'd8;
        for (int c = 0; c < 100 && done_at < 0; c++) begin
            bus.rd_ready = pat[c % 4];
            @(negedge clk);
            outst = iss - pops;
            if (outst > 2 || (outst - int'(bus.rd_valid && bus.rd_ready) >= 2 && bus.ram_EN0)) viol++;
            if (c > 0 && bus.cmd_ready) viol++;
            if (bus.ram_EN0) iss++;
            if (bus.rd_valid && bus.rd_ready) begin
                if (bus.rd_data != 32'h100 + 32'(rd_n) || bus.rd_last != (rd_n == 7)) derr++;
                rd_n++;
                pops++;
            end
            if (bus.done) done_at = c;
            else begin
                @(posedge clk); #1;
                bus.cmd_write = 1'b1; bus.cmd_len = 10'd0;
            end
        end
        bus.cmd_valid = 1'b0; bus.rd_ready = 1'b1;
        chk("bp words", rd_n, 32'd8);
        chk("bp issues", iss, 32'd8);
        chk("bp data_order", derr, 32'd0);
        chk("bp occupancy", viol, 32'd0);
        chk("bp done_seen", 32'(done_at > 0), 32'd1);
        @(posedge clk); #1;

        // Reset in cycle 4 of a 16-word read
        bad = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 9'h010; bus.cmd_len = 10'd16;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) chk("mid rd_valid_before", 32'(bus.rd_valid), 32'd1);
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("mid rst ram_EN0", 32'(bus.ram_EN0), 32'd0);
        chk("mid rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 5; c < 10; c++) begin
            @(negedge clk);
            if (c == 5) chk("mid cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
            if (bus.rd_valid || bus.ram_EN0 || bus.done) bad++;
            @(posedge clk); #1;
        end
        chk("mid quiet_after_rst", bad, 32'd0);
        rv = '{1'b0, 9'h1FE, 10'd2, 32'h000000A0, 4'h0, 5};
        run_vec(rv, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
